// File: rtl/boa_uart_bus_bridge.sv
// UART-to-bus debug bridge: parses ping/write/read command frames from the
// receive byte stream, performs single-word bus accesses and returns reply bytes.
module boa_uart_bus_bridge #(
    parameter int unsigned tlen    = 16,
    parameter int unsigned timeout = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic        bus_re,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        st_idle,
        st_addr,
        st_data,
        st_bus,
        st_resp
    } state_t;

    localparam logic [tlen-1:0] tmo_val = tlen'(timeout);
    localparam bit              tmo_en  = (timeout != 0);

    state_t            state;
    logic              is_write;
    logic [1:0]        byte_cnt;
    logic [29:0]       addr_sh;
    logic [23:0]       data_sh;
    logic [31:0]       rdata_q;
    logic [2:0]        resp_left;
    logic [tlen-1:0]   tcnt;
    logic              bus_first;

    logic rx_fire;
    logic tx_fire;
    logic tmo_hit;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;
    assign tmo_hit = tmo_en && (tcnt == tmo_val);

    // Address shifter drops byte-address bits 1:0 as the first byte falls off the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= st_idle;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            addr_sh   <= 30'd0;
            data_sh   <= 24'd0;
            rdata_q   <= 32'd0;
            resp_left <= 3'd0;
            tcnt      <= '0;
            bus_first <= 1'b0;
            rx_ready  <= 1'b0;
            tx_byte   <= 8'd0;
            tx_valid  <= 1'b0;
            bus_addr  <= 30'd0;
            bus_we    <= 4'd0;
            bus_re    <= 1'b0;
            bus_wdata <= 32'd0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                st_idle: begin
                    tcnt     <= '0;
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        byte_cnt  <= 2'd0;
                        busy      <= 1'b1;
                        resp_left <= 3'd0;
                        case (rx_byte)
                            8'h00: begin
                                state    <= st_resp;
                                rx_ready <= 1'b0;
                                tx_valid <= 1'b1;
                                tx_byte  <= 8'hA5;
                            end
                            8'h01, 8'h02: begin
                                state    <= st_addr;
                                is_write <= (rx_byte == 8'h01);
                            end
                            default: begin
                                state     <= st_resp;
                                rx_ready  <= 1'b0;
                                tx_valid  <= 1'b1;
                                tx_byte   <= 8'hEE;
                                frame_err <= 1'b1;
                            end
                        endcase
                    end
                end

                st_addr: begin
                    if (rx_fire) begin
                        tcnt     <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        addr_sh  <= {rx_byte, addr_sh[29:8]};
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= st_data;
                            end else begin
                                state     <= st_bus;
                                rx_ready  <= 1'b0;
                                bus_first <= 1'b1;
                                bus_addr  <= {rx_byte, addr_sh[29:8]};
                                bus_re    <= 1'b1;
                                bus_we    <= 4'd0;
                            end
                        end
                    end else if (tmo_hit) begin
                        state     <= st_idle;
                        busy      <= 1'b0;
                        byte_cnt  <= 2'd0;
                        frame_err <= 1'b1;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                st_data: begin
                    if (rx_fire) begin
                        tcnt     <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        data_sh  <= {rx_byte, data_sh[23:8]};
                        if (byte_cnt == 2'd3) begin
                            state     <= st_bus;
                            rx_ready  <= 1'b0;
                            bus_first <= 1'b1;
                            bus_addr  <= addr_sh;
                            bus_wdata <= {rx_byte, data_sh};
                            bus_we    <= 4'b1111;
                            bus_re    <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state     <= st_idle;
                        busy      <= 1'b0;
                        byte_cnt  <= 2'd0;
                        frame_err <= 1'b1;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                // bus_ready in the first cycle still belongs to the previous access.
                st_bus: begin
                    if (bus_first) begin
                        bus_first <= 1'b0;
                    end else if (bus_ready) begin
                        rdata_q   <= bus_rdata;
                        bus_addr  <= 30'd0;
                        bus_we    <= 4'd0;
                        bus_re    <= 1'b0;
                        bus_wdata <= 32'd0;
                        state     <= st_resp;
                        tx_valid  <= 1'b1;
                        tx_byte   <= is_write ? 8'h81 : 8'h82;
                        resp_left <= is_write ? 3'd0 : 3'd4;
                    end
                end

                st_resp: begin
                    if (tx_fire) begin
                        if (resp_left == 3'd0) begin
                            state    <= st_idle;
                            tx_valid <= 1'b0;
                            tx_byte  <= 8'd0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                        end else begin
                            resp_left <= resp_left - 3'd1;
                            tx_byte   <= rdata_q[7:0];
                            rdata_q   <= {8'd0, rdata_q[31:8]};
                        end
                    end
                end

                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boa_uart_bus_bridge.sv
// Directed self-checking bench for boa_uart_bus_bridge with a wait-state bus slave
// and a reply collector on the transmit side.
module tb_boa_uart_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [29:0] bus_addr;
    logic [3:0]  bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ready = 1'b0;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    boa_uart_bus_bridge #(.tlen(16), .timeout(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .busy      (busy),
        .frame_err (frame_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Transmit collector and bus slave state.
    bit          tx_rand = 1'b0;
    bit          tx_hold = 1'b0;
    logic [7:0]  txq[$];
    int          ferr_cnt = 0;
    int          n_access = 0;
    int          k = 0;
    int          held = 0;
    int          wait_n = 0;
    bit          stale = 1'b0;
    logic [31:0] rdata_val = 32'd0;
    logic [29:0] last_addr = 30'd0;
    logic [3:0]  last_we = 4'd0;
    logic        last_re = 1'b0;
    logic [31:0] last_wdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] txb(input int i);
        if (i < txq.size()) return 32'(txq[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Slave answers with ready after wait_n extra cycles; optional stale ready in cycle 1.
    always @(negedge clk) begin
        if (tx_hold) tx_ready = 1'b0;
        else if (tx_rand) tx_ready = 1'($urandom_range(0, 1));
        else tx_ready = 1'b1;
        if (tx_valid && tx_ready) txq.push_back(tx_byte);
        if (frame_err) ferr_cnt++;
        if (bus_re || (bus_we != 4'd0)) begin
            if (k == 0) begin
                n_access++;
                last_addr  = bus_addr;
                last_we    = bus_we;
                last_re    = bus_re;
                last_wdata = bus_wdata;
            end
            k++;
            held = k;
            bus_ready = ((k == 1) && stale) || (k > wait_n + 1);
            bus_rdata = !bus_ready ? 32'd0 : ((k == 1) ? 32'hBADB_AD00 : rdata_val);
        end else begin
            k = 0;
            bus_ready = 1'b0;
            bus_rdata = 32'd0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f [9], input int n);
        for (int i = 0; i < n; i++) send_byte(f[i]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_ping(input string tag);
        txq.delete();
        send_byte(8'h00);
        wait_idle({tag, "_idle"}, 50);
        check({tag, "_n"}, 32'(txq.size()), 32'd1);
        check({tag, "_b"}, txb(0), 32'hA5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] f[9];
        int acc0;
        int ferr0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_re", 32'(bus_re), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_rx_ready", 32'(rx_ready), 32'd1);

        // Ping: reply one cycle after the opcode edge, no bus activity.
        acc0 = n_access;
        txq.delete();
        send_byte(8'h00);
        check("ping_lat", 32'(tx_valid), 32'd1);
        check("ping_busy", 32'(busy), 32'd1);
        wait_idle("ping_idle", 50);
        check("ping_n", 32'(txq.size()), 32'd1);
        check("ping_b", txb(0), 32'hA5);
        check("ping_nobus", 32'(n_access - acc0), 32'd0);

        // Write with zero-wait slave.
        acc0 = n_access; wait_n = 0; stale = 1'b0; txq.delete();
        f = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h80, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(f, 9);
        check("wr_entry_we", 32'(bus_we), 32'hF);
        wait_idle("wr_idle", 100);
        check("wr_access", 32'(n_access - acc0), 32'd1);
        check("wr_addr", 32'(last_addr), 32'h2000_0002);
        check("wr_we", 32'(last_we), 32'hF);
        check("wr_re", 32'(last_re), 32'd0);
        check("wr_wdata", last_wdata, 32'h1234_5678);
        check("wr_held", 32'(held), 32'd2);
        check("wr_n", 32'(txq.size()), 32'd1);
        check("wr_b", txb(0), 32'h81);

        // Read with stale ready, 5 wait states, random tx_ready.
        acc0 = n_access; wait_n = 5; stale = 1'b1; rdata_val = 32'hDEAD_BEEF;
        tx_rand = 1'b1; txq.delete();
        f = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 5);
        check("rd_entry_re", 32'(bus_re), 32'd1);
        check("rd_rx_ready", 32'(rx_ready), 32'd0);
        wait_idle("rd_idle", 300);
        tx_rand = 1'b0; stale = 1'b0; wait_n = 0;
        check("rd_access", 32'(n_access - acc0), 32'd1);
        check("rd_addr", 32'(last_addr), 32'h2000_0001);
        check("rd_we", 32'(last_we), 32'd0);
        check("rd_held", 32'(held), 32'd7);
        check("rd_n", 32'(txq.size()), 32'd5);
        check("rd_b0", txb(0), 32'h82);
        check("rd_b1", txb(1), 32'hEF);
        check("rd_b2", txb(2), 32'hBE);
        check("rd_b3", txb(3), 32'hAD);
        check("rd_b4", txb(4), 32'hDE);

        // Unknown opcode.
        ferr0 = ferr_cnt; txq.delete();
        send_byte(8'h7F);
        check("unk_ferr_now", 32'(frame_err), 32'd1);
        wait_idle("unk_idle", 50);
        check("unk_ferr_cnt", 32'(ferr_cnt - ferr0), 32'd1);
        check("unk_n", 32'(txq.size()), 32'd1);
        check("unk_b", txb(0), 32'hEE);
        do_ping("unk_ping");

        // Inter-byte timeout of 20 cycles.
        acc0 = n_access; ferr0 = ferr_cnt; txq.delete();
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (15) @(negedge clk);
        check("tmo_early", 32'(ferr_cnt - ferr0), 32'd0);
        check("tmo_busy", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        check("tmo_ferr", 32'(ferr_cnt - ferr0), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_noreply", 32'(txq.size()), 32'd0);
        check("tmo_nobus", 32'(n_access - acc0), 32'd0);
        rdata_val = 32'h0BAD_F00D; txq.delete();
        f = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 5);
        wait_idle("tmo_rd_idle", 100);
        check("tmo_rd_addr", 32'(last_addr), 32'h0000_0040);
        check("tmo_rd_n", 32'(txq.size()), 32'd5);
        check("tmo_rd_b0", txb(0), 32'h82);
        check("tmo_rd_b1", txb(1), 32'h0D);
        check("tmo_rd_b4", txb(4), 32'h0B);

        // Reset while the bus access is stalled.
        wait_n = 1000;
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 5);
        repeat (3) @(negedge clk);
        check("rb_pre_re", 32'(bus_re), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rb_re", 32'(bus_re), 32'd0);
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1; wait_n = 0;
        @(negedge clk);
        do_ping("rb_ping");

        // Reset in the middle of a held-off reply.
        tx_hold = 1'b1; rdata_val = 32'h1122_3344; txq.delete();
        send_frame(f, 5);
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_pre_valid", 32'(tx_valid), 32'd1);
        check("rr_pre_byte", 32'(tx_byte), 32'h82);
        #2 rst = 1'b0;
        #1;
        check("rr_valid", 32'(tx_valid), 32'd0);
        check("rr_byte", 32'(tx_byte), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1; tx_hold = 1'b0;
        @(negedge clk);
        do_ping("rr_ping");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
